fifo_array_skew_reader: RTL
===========================

Name: fifo_array_skew_reader

Overview:
- Read-side controller for the FIFO array: issues per-lane read enables in a diagonal (systolic) skew, so lane i starts reading i cycles after lane 0.
- Each lane is drained by a programmed word count, feeding the PE array's skewed inputs.
- Stalls the whole wavefront when any active lane's FIFO is empty.
- Returns per-lane valid strobes aligned with the array's out_bus.

Parameters:
- data_size, 8, bits per FIFO word
- array_size, 9, number of FIFO lanes (≥1)
- log_len, 12, width of the per-lane word count; len max = 2^log_len-1

Ports:
- clk  input  1  single clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE
- len  input  log_len  words to read per lane; captured on accepted start
- empty  input  array_size  per-lane empty flags from the FIFO array
- fifo_data  input  data_size*array_size  out_bus of the FIFO array; lane i = bits [(i+1)*data_size-1 : i*data_size]
- r_en  output  array_size  per-lane read enables to the FIFO array
- data_out  output  data_size*array_size  registered lane data toward the PE array
- data_valid  output  array_size  per-lane valid for data_out
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (async): state=IDLE; t=0; len_q=0. r_en, data_valid, data_out, busy and done are all 0.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE -> RUN on start. Captures len_q=len and sets t=0; busy rises the next cycle. If len==0, goes IDLE -> DONE directly with no reads.
- start while not IDLE is ignored.
- Tick counter t: width log_len+clog2(array_size)+1.
- Lane i is active when i ≤ t < i+len_q.
- stall = OR over active lanes of empty[i].
- r_en[i] = (state==RUN) & active_i & ~stall. It is combinational from registered t and the empty inputs, so there is no zero-latency combinational path from start.
- t increments by 1 on each RUN cycle with ~stall; it holds on stall. The skew between lanes is therefore preserved across stalls.
- RUN -> FLUSH on the non-stalled cycle where t == len_q+array_size-2, i.e. the last read of lane array_size-1.
- FIFO read latency is one cycle: fifo_data lane i is valid the cycle after r_en[i].
- Output capture: in the cycle after r_en[i], data_out lane i <= fifo_data lane i and data_valid[i]=1. This is pipelined by one register stage, so data_valid[i] rises two cycles after r_en[i]. data_out holds its value when data_valid[i]=0.
- FLUSH lasts two cycles, to let the last reads land. It then moves to DONE.
- DONE lasts one cycle: done=1, busy=0. DONE -> IDLE.
- busy=1 in RUN and FLUSH.
- Per lane, exactly len_q r_en pulses and exactly len_q data_valid pulses occur per burst. Lane i's first r_en comes exactly i non-stalled cycles after lane 0's first.
- empty on an inactive lane is ignored.
- Reset mid-burst: aborts immediately, r_en drops asynchronously, and no done pulse is produced.
- r_en is never asserted while the corresponding empty[i]=1.

Test Plan:
- array_size=3, len=4, all empty=0, start pulse -> r_en[0] high for t=0..3, r_en[1] for t=1..4, r_en[2] for t=2..5. 4 data_valid pulses per lane, each 2 cycles after its r_en, with data matching the FIFO contents. done pulses once, 9 cycles after start acceptance.
- Same burst, but empty[1]=1 forced for 3 cycles at t=2 -> all r_en drop for 3 cycles and t holds at 2. Skew is preserved, per-lane counts stay 4, and done is delayed by exactly 3 cycles.
- empty[2]=1 at t=0 (lane 2 not yet active) -> no stall; r_en[0] asserts at t=0.
- len=0 with start -> no r_en and no data_valid; done pulses one cycle after start; busy never rises.
- start re-pulsed during RUN -> ignored; the burst completes with its original len.
- reset asserted mid-RUN at t=3 -> r_en, data_valid and busy go to 0 without waiting for clk; no done pulse. A subsequent start with len=2 runs a clean 2-word burst.

Source files
------------

// File: rtl/fifo_array_skew_reader.sv
// Read-side controller for the FIFO array. Lane read enables follow a diagonal
// wavefront; any empty flag on an active lane stalls the entire wavefront.
module fifo_array_skew_reader #(
  parameter int unsigned data_size  = 8,
  parameter int unsigned array_size = 9,
  parameter int unsigned log_len    = 12
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [log_len-1:0]              len,
  input  logic [array_size-1:0]           empty,
  input  logic [data_size*array_size-1:0] fifo_data,
  output logic [array_size-1:0]           r_en,
  output logic [data_size*array_size-1:0] data_out,
  output logic [array_size-1:0]           data_valid,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned TW = log_len + $clog2(array_size) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [TW-1:0]         r_t;
  logic [TW-1:0]         w_t_nxt;
  logic [log_len-1:0]    r_len_q;
  logic [log_len-1:0]    w_len_nxt;
  logic                  r_flush;
  logic                  w_flush_nxt;
  logic                  r_busy;
  logic                  r_done;
  logic [array_size-1:0] r_rd_d;
  logic [array_size-1:0] w_active;
  logic                  w_stall;
  logic                  w_last;

  // Lane i is inside its read window when i <= t < i + len_q
  always_comb begin
    w_active = '0;
    for (int i = 0; i < int'(array_size); i++) begin
      w_active[i] = (r_t >= TW'(i)) && (r_t < (TW'(i) + TW'(r_len_q)));
    end
  end

  assign w_stall = |(w_active & empty);
  assign w_last  = (r_t == (TW'(r_len_q) + TW'(array_size) - TW'(2)));

  always_comb begin
    r_en = '0;
    if ((r_state == S_RUN) && !w_stall) begin
      r_en = w_active;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_len_nxt   = r_len_q;
    w_flush_nxt = r_flush;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_len_nxt   = len;
          w_t_nxt     = '0;
          w_state_nxt = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (!w_stall) begin
          w_t_nxt = r_t + TW'(1);
          if (w_last) begin
            w_state_nxt = S_FLUSH;
            w_flush_nxt = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        w_flush_nxt = 1'b1;
        if (r_flush) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_len_q <= '0;
      r_flush <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
      r_len_q <= w_len_nxt;
      r_flush <= w_flush_nxt;
      r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_FLUSH);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  // FIFO data lands one cycle after r_en; capture it one stage later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_d     <= '0;
      data_valid <= '0;
      data_out   <= '0;
    end else begin
      r_rd_d     <= r_en;
      data_valid <= r_rd_d;
      for (int i = 0; i < int'(array_size); i++) begin
        if (r_rd_d[i]) begin
          data_out[i*int'(data_size) +: data_size] <= fifo_data[i*int'(data_size) +: data_size];
        end
      end
    end
  end

endmodule
